game_controller: RTL and testbench
==================================

Name: game_controller

Overview:
- Top-level game-flow FSM for whack-a-mole. Sits directly upstream of the countdown timer.
- Debounces the raw start button and drives the one-cycle restart pulse into the timer.
- Watches the timer's game-over flag to end a round.
- Counts mole hits into a saturating score and keeps a high score. Downstream display logic reads both.

Parameters:
- DEBOUNCE_CYCLES, 10000: consecutive synced cycles an input change must persist before it is accepted. Simulation value; 1,000,000 on hardware.
- SCORE_W, 8: width of the score and high-score registers.

Ports:
- clk  input  1  system clock (100 MHz on board).
- rst  input  1  synchronous, active-high reset.
- i_btn_start  input  1  raw, asynchronous, bouncing start/restart button.
- i_game_over  input  1  level from the countdown timer; 1 when time has expired.
- i_hit  input  1  one-cycle pulse per successful mole whack.
- o_restart_game  output  1  one-cycle pulse to the countdown timer's restart input.
- o_playing  output  1  high while in PLAYING.
- o_state  output  2  current FSM state encoding.
- o_score  output  SCORE_W  current-round score.
- o_high_score  output  SCORE_W  best completed-round score since reset.

Behaviour:
- Clock and reset:
  - Single clock, synchronous active-high reset, all state updated on posedge clk.
  - While rst=1, all registers clear at each edge: state=IDLE, sync flops=0, debounced level=0, debounce count=0, press=0, o_score=0, o_high_score=0.
  - Consequently o_restart_game=0 and o_playing=0.
  - Reset mid-round abandons the round with no high-score update.
- Synchroniser: i_btn_start passes through 2 flops (sync1, sync2).
- Debounce:
  - At each edge, if sync2 equals the debounced level, the count clears to 0.
  - Otherwise, if count==DEBOUNCE_CYCLES-1, the debounced level flips and the count clears to 0.
  - Otherwise the count increments.
  - The count is $clog2(DEBOUNCE_CYCLES) bits and never wraps.
  - press is a registered pulse, high for exactly the one cycle after the edge where the debounced level flips 0->1.
  - A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no press.
- Latency: raw rise before edge 0 -> sync2=1 after edge 2 -> debounced flips and press=1 after edge 2+DEBOUNCE_CYCLES -> state=START after edge 3+DEBOUNCE_CYCLES -> PLAYING after edge 4+DEBOUNCE_CYCLES.
- FSM (encodings in package): IDLE=0, START=1, PLAYING=2, OVER=3.
  - IDLE: press -> START; else stay.
  - START: exactly one cycle.
    - o_restart_game=1, o_score clears to 0 at the exiting edge, then -> PLAYING unconditionally.
    - The timer clears game_over at that same edge, so i_game_over reads 0 in the first PLAYING cycle.
  - PLAYING: priority press > i_game_over > i_hit.
    - press -> START (mid-round restart, no high-score update).
    - else i_game_over=1 -> OVER; o_high_score <= max(o_high_score, o_score); i_hit in that cycle is ignored.
    - else i_hit=1 -> o_score+1, saturating at 2^SCORE_W-1.
  - OVER: o_score is held; press -> START; else stay.
- Outputs are Moore, decoded from registered state: o_restart_game = (state==START), o_playing = (state==PLAYING), o_state = state.
- i_hit outside PLAYING is ignored.
- i_game_over outside PLAYING is ignored, including a stale 1 during START/IDLE.
- Holding the button produces only one press. A new press requires a debounced release, then another debounced press.

Decomposition:
- game_pkg holds:
  - state localparams STATE_IDLE/STATE_START/STATE_PLAYING/STATE_OVER, 2 bits;
  - SCORE_W default;
  - DEBOUNCE_CYCLES simulation and hardware constants.
- One sub-module, button_debouncer (params DEBOUNCE_CYCLES; ports clk, rst, i_raw, o_level, o_press). It contains the synchroniser, the counter and the rising-edge pulse.
- The FSM and score logic stay in game_controller.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then idle 20 cycles -> state=0, o_score=0, o_high_score=0, o_restart_game never 1.
- Raw button high from before edge 0, held -> press after edge 6, o_restart_game=1 for exactly the cycle after edge 7, state=2 after edge 8. Holding 50 more cycles gives no second pulse.
- Button bounces 1,0,1,0 every 2 cycles then settles low -> no press, state remains IDLE.
- In PLAYING, 5 i_hit pulses, then i_game_over=1 together with a 6th i_hit -> state=3, o_score=5, o_high_score=5.
- Second round: 3 hits then game over -> o_score=3, o_high_score stays 5. Third round with 300 hits -> o_score saturates at 255, then o_high_score=255 at game over.
- Press during PLAYING with o_score=7 -> one restart pulse, o_score=0, o_high_score unchanged. rst mid-round -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared constants for the whack-a-mole game-flow controller.
//   - STATE_* : 2-bit FSM encodings, also exposed on game_controller.o_state
//   - state_e : enum view of the same encodings for the FSM
//   - SCORE_W_DEFAULT        : default score register width
//   - DEBOUNCE_CYCLES_SIM/HW : debounce lengths for simulation and the board
package game_pkg;

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_START   = 2'd1;
    localparam logic [1:0] STATE_PLAYING = 2'd2;
    localparam logic [1:0] STATE_OVER    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = STATE_IDLE,
        S_START   = STATE_START,
        S_PLAYING = STATE_PLAYING,
        S_OVER    = STATE_OVER
    } state_e;

    localparam int SCORE_W_DEFAULT     = 8;
    localparam int DEBOUNCE_CYCLES_SIM = 10000;
    localparam int DEBOUNCE_CYCLES_HW  = 1000000;

endpackage

// File: rtl/game_controller_debouncer.sv
// button_debouncer: synchronises a raw bouncing button, filters it and emits
// a one-cycle pulse on each accepted press.
//   clk, rst : clock, synchronous active-high reset
//   i_raw    : raw asynchronous button input
//   o_level  : debounced button level
//   o_press  : registered one-cycle pulse, high the cycle after the edge at
//              which the debounced level rises
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    // A count of one bit still works for DEBOUNCE_CYCLES of 1 or 2.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             press;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= i_raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                // Any return to the accepted level restarts the qualification.
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= ~level;
                cnt   <= '0;
                // Only the 0->1 flip is a press; releases are silent.
                press <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_level = level;
    assign o_press = press;

endmodule

// File: rtl/game_controller.sv
// game_controller: top-level game-flow FSM for whack-a-mole.
//   clk, rst       : clock, synchronous active-high reset
//   i_btn_start    : raw bouncing start/restart button
//   i_game_over    : countdown timer expired flag (level)
//   i_hit          : one-cycle pulse per successful whack
//   o_restart_game : one-cycle restart pulse to the countdown timer
//   o_playing      : high while a round is in progress
//   o_state        : current FSM state encoding (game_pkg STATE_*)
//   o_score        : current-round score, saturating
//   o_high_score   : best completed-round score since reset
module game_controller
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
    parameter int SCORE_W         = SCORE_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_btn_start,
    input  logic               i_game_over,
    input  logic               i_hit,
    output logic               o_restart_game,
    output logic               o_playing,
    output logic [1:0]         o_state,
    output logic [SCORE_W-1:0] o_score,
    output logic [SCORE_W-1:0] o_high_score
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_e             state;
    state_e             state_nxt;
    logic               press;
    logic               btn_level;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (i_btn_start),
        .o_level(btn_level),
        .o_press(press)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:    if (press) state_nxt = S_START;
            S_START:   state_nxt = S_PLAYING;
            S_PLAYING: begin
                // A restart press wins over an expiring timer in the same cycle.
                if (press)            state_nxt = S_START;
                else if (i_game_over) state_nxt = S_OVER;
            end
            S_OVER:    if (press) state_nxt = S_START;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Score clears on the way out of START so the previous round's result
    // stays visible in OVER until the next round actually begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            score      <= '0;
            high_score <= '0;
        end else begin
            case (state)
                S_START: score <= '0;
                S_PLAYING: begin
                    if (!press) begin
                        if (i_game_over) begin
                            // Round completes; the same-cycle hit is dropped.
                            if (score > high_score) high_score <= score;
                        end else if (i_hit && score != SCORE_MAX) begin
                            score <= score + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_restart_game = (state == S_START);
    assign o_playing      = (state == S_PLAYING);
    assign o_state        = state;
    assign o_score        = score;
    assign o_high_score   = high_score;

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_btn_start = 1'b0;
    logic       i_game_over = 1'b0;
    logic       i_hit = 1'b0;
    logic       o_restart_game;
    logic       o_playing;
    logic [1:0] o_state;
    logic [7:0] o_score;
    logic [7:0] o_high_score;

    int tests = 0;
    int fails = 0;

    game_controller #(
        .DEBOUNCE_CYCLES(4),
        .SCORE_W        (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_btn_start   (i_btn_start),
        .i_game_over   (i_game_over),
        .i_hit         (i_hit),
        .o_restart_game(o_restart_game),
        .o_playing     (o_playing),
        .o_state       (o_state),
        .o_score       (o_score),
        .o_high_score  (o_high_score)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       btn;
        logic       go;
        logic       hit;
        logic [1:0] st;
        logic [7:0] sc;
        logic [7:0] hi;
        logic       rs;
        logic       pl;
    } vec_t;

    vec_t vt [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic hit_n(input int n);
        for (int i = 0; i < n; i++) begin
            i_hit = 1'b1;
            tick();
            i_hit = 1'b0;
            tick();
        end
    endtask

    // Press and hold until the restart pulse, let START exit (timer clears
    // game_over at that edge), then release and wait out the debounce.
    task automatic start_round(input string tag);
        int pulses;
        bit seen;
        pulses = 0;
        seen   = 1'b0;
        i_btn_start = 1'b1;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (o_restart_game) begin
                pulses++;
                seen = 1'b1;
            end
        end
        chk({tag, "_restart_seen"}, int'(seen), 1);
        tick();
        i_game_over = 1'b0;
        chk({tag, "_state_playing"}, int'(o_state), 2);
        chk({tag, "_score_cleared"}, int'(o_score), 0);
        i_btn_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_restart_game) pulses++;
        end
        chk({tag, "_one_pulse"}, pulses, 1);
    endtask

    initial begin
        int bad;
        logic bounce [8];

        // Edge 0 of the latency table is a reset edge with the button
        // already high; sync1 first captures it at edge 1.
        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0};
        for (int i = 1; i <= 6; i++)
            vt[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd0, 8'd0, 1'b1, 1'b0};
        vt[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 8'd0, 1'b0, 1'b1};
        vt[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 8'd0, 1'b0, 1'b1};

        // Reset, then idle.
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_state", int'(o_state), 0);
        chk("reset_playing", int'(o_playing), 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_restart_game || o_state != 2'd0) bad++;
        end
        chk("idle_no_restart", bad, 0);
        chk("idle_score", int'(o_score), 0);
        chk("idle_high", int'(o_high_score), 0);

        // Bounce 1,0,1,0 in 2-cycle steps, then settle low.
        bounce = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            i_btn_start = (i < 8) ? bounce[i] : 1'b0;
            tick();
            if (o_restart_game || o_state != 2'd0) bad++;
        end
        chk("bounce_no_press", bad, 0);

        // Table-driven start latency.
        for (int i = 0; i < 10; i++) begin
            rst         = vt[i].rst;
            i_btn_start = vt[i].btn;
            i_game_over = vt[i].go;
            i_hit       = vt[i].hit;
            tick();
            chk($sformatf("vec%0d_state", i), int'(o_state), int'(vt[i].st));
            chk($sformatf("vec%0d_score", i), int'(o_score), int'(vt[i].sc));
            chk($sformatf("vec%0d_high", i), int'(o_high_score), int'(vt[i].hi));
            chk($sformatf("vec%0d_restart", i), int'(o_restart_game), int'(vt[i].rs));
            chk($sformatf("vec%0d_playing", i), int'(o_playing), int'(vt[i].pl));
        end

        // Holding the button must not produce another press.
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (o_restart_game) bad++;
        end
        chk("hold_no_second_pulse", bad, 0);
        i_btn_start = 1'b0;
        repeat (8) tick();
        chk("release_still_playing", int'(o_state), 2);

        // Round 1: five hits, then game over with a simultaneous hit.
        hit_n(5);
        chk("r1_score5", int'(o_score), 5);
        i_game_over = 1'b1;
        i_hit = 1'b1;
        tick();
        i_hit = 1'b0;
        chk("r1_over_state", int'(o_state), 3);
        chk("r1_over_score", int'(o_score), 5);
        chk("r1_over_high", int'(o_high_score), 5);
        hit_n(2);
        chk("over_hit_ignored", int'(o_score), 5);

        // Round 2: lower score keeps the high score.
        start_round("r2");
        hit_n(3);
        i_game_over = 1'b1;
        tick();
        chk("r2_over_state", int'(o_state), 3);
        chk("r2_score", int'(o_score), 3);
        chk("r2_high", int'(o_high_score), 5);

        // Round 3: saturation.
        start_round("r3");
        hit_n(300);
        chk("r3_saturated", int'(o_score), 255);
        i_game_over = 1'b1;
        tick();
        chk("r3_over_state", int'(o_state), 3);
        chk("r3_high", int'(o_high_score), 255);

        // Round 4: mid-round restart, then reset mid-round.
        start_round("r4");
        hit_n(7);
        chk("r4_score7", int'(o_score), 7);
        start_round("r4mid");
        chk("r4mid_high_kept", int'(o_high_score), 255);
        hit_n(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_state", int'(o_state), 0);
        chk("rst_score", int'(o_score), 0);
        chk("rst_high", int'(o_high_score), 0);
        chk("rst_restart", int'(o_restart_game), 0);
        chk("rst_playing", int'(o_playing), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
